// File: rtl/spi_command_queue.sv
// spi_command_queue
//   Buffers SPI transfer commands from the fabric and launches them on a
//   quick_spi master, one at a time, collecting each received word into a
//   response FIFO.  A response slot is reserved before every launch, so the
//   unstallable data_valid strobe from quick_spi always finds room.
//
// Ports
//   clk_i, rst_ni          clock shared with quick_spi; async active-low reset
//   cmd_valid_i/_ready_o   command handshake, cmd_num_data_i / cmd_data_i payload
//   resp_valid_o/_ready_i  response handshake, resp_data_o payload (FIFO head)
//   spi_request_o          to quick_spi.request_i
//   spi_num_data_o         to quick_spi.num_data_i (head command)
//   spi_data_o             to quick_spi.data_i (head command)
//   spi_data_i             from quick_spi.data_o
//   spi_data_valid_i       from quick_spi.data_valid_o
//   spi_cs_n_i             from quick_spi.cs_n_o; its falling edge acknowledges a launch
//   busy_o                 transfer in progress or commands still queued
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high.  Ready/valid come only from registered
// FIFO counts, so a full FIFO reports not-ready even in a cycle where it is
// being read, and an empty one reports not-valid even while being written.
module spi_command_queue #(
    parameter  int MAX_DATA_LENGTH = 16,
    parameter  int NUM_DEVICES     = 1,
    parameter  int CMD_DEPTH       = 4,
    parameter  int RESP_DEPTH      = 4,
    localparam int NUM_DATA_WIDTH  = $clog2(MAX_DATA_LENGTH),
    localparam int W               = MAX_DATA_LENGTH * NUM_DEVICES
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [NUM_DATA_WIDTH-1:0] cmd_num_data_i,
    input  logic [W-1:0]              cmd_data_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [W-1:0]              resp_data_o,
    output logic                      spi_request_o,
    output logic [NUM_DATA_WIDTH-1:0] spi_num_data_o,
    output logic [W-1:0]              spi_data_o,
    input  logic [W-1:0]              spi_data_i,
    input  logic                      spi_data_valid_i,
    input  logic                      spi_cs_n_i,
    output logic                      busy_o
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int CCW = CAW + 1;
    localparam int RAW = $clog2(RESP_DEPTH);
    localparam int RCW = RAW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_ACTIVE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [NUM_DATA_WIDTH-1:0] cmd_num_mem  [CMD_DEPTH];
    logic [W-1:0]              cmd_data_mem [CMD_DEPTH];
    logic [CAW-1:0]            cmd_wr_ptr_q, cmd_wr_ptr_d;
    logic [CAW-1:0]            cmd_rd_ptr_q, cmd_rd_ptr_d;
    logic [CCW-1:0]            cmd_count_q, cmd_count_d;

    logic [W-1:0]              resp_mem [RESP_DEPTH];
    logic [RAW-1:0]            resp_wr_ptr_q, resp_wr_ptr_d;
    logic [RAW-1:0]            resp_rd_ptr_q, resp_rd_ptr_d;
    logic [RCW-1:0]            resp_count_q, resp_count_d;

    logic last_cs_n_q;
    logic ready_en_q;   // holds cmd_ready_o low until the first edge after reset

    logic cmd_push, cmd_pop, cmd_empty;
    logic resp_push, resp_pop;
    logic cs_fall, pend, can_launch;

    assign cmd_empty    = (cmd_count_q == '0);
    assign cmd_ready_o  = ready_en_q && (cmd_count_q != CCW'(CMD_DEPTH));
    assign cmd_push     = cmd_valid_i && cmd_ready_o;

    assign resp_valid_o = (resp_count_q != '0);
    assign resp_pop     = resp_valid_o && resp_ready_i;

    assign cs_fall      = !spi_cs_n_i && last_cs_n_q;

    // A transfer already launched (or being launched) owns one response slot.
    // A response leaving the FIFO in the same cycle is deliberately not counted.
    assign pend         = (state_q != S_IDLE);
    assign can_launch   = !cmd_empty && ((resp_count_q + RCW'(pend)) < RCW'(RESP_DEPTH));

    assign busy_o       = pend || !cmd_empty;

    // Heads read as zero when empty so nothing undefined leaks out of reset.
    assign spi_num_data_o = cmd_empty ? '0 : cmd_num_mem[cmd_rd_ptr_q];
    assign spi_data_o     = cmd_empty ? '0 : cmd_data_mem[cmd_rd_ptr_q];
    assign resp_data_o    = resp_valid_o ? resp_mem[resp_rd_ptr_q] : '0;

    // ---------------- sequencer: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- sequencer: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (can_launch) state_d = S_LAUNCH;
            S_LAUNCH: if (cs_fall) state_d = S_ACTIVE;
            // Chaining: if another command can go, request during the strobe
            // so quick_spi picks it up without passing through IDLE.
            S_ACTIVE: if (spi_data_valid_i) state_d = can_launch ? S_LAUNCH : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- sequencer: outputs ----------------
    always_comb begin
        spi_request_o = 1'b0;
        cmd_pop       = 1'b0;
        resp_push     = 1'b0;
        case (state_q)
            S_LAUNCH: begin
                // Held until cs_n falls so a request made while quick_spi is
                // still coming out of its own reset is not lost.
                spi_request_o = 1'b1;
                cmd_pop       = cs_fall;
            end
            S_ACTIVE: begin
                spi_request_o = spi_data_valid_i && can_launch;
                resp_push     = spi_data_valid_i;
            end
            default: ;
        endcase
    end

    // ---------------- FIFO bookkeeping ----------------
    always_comb begin
        cmd_wr_ptr_d  = cmd_wr_ptr_q + CAW'(cmd_push);
        cmd_rd_ptr_d  = cmd_rd_ptr_q + CAW'(cmd_pop);
        cmd_count_d   = cmd_count_q + CCW'(cmd_push) - CCW'(cmd_pop);
        resp_wr_ptr_d = resp_wr_ptr_q + RAW'(resp_push);
        resp_rd_ptr_d = resp_rd_ptr_q + RAW'(resp_pop);
        resp_count_d  = resp_count_q + RCW'(resp_push) - RCW'(resp_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_wr_ptr_q  <= '0;
            cmd_rd_ptr_q  <= '0;
            cmd_count_q   <= '0;
            resp_wr_ptr_q <= '0;
            resp_rd_ptr_q <= '0;
            resp_count_q  <= '0;
            last_cs_n_q   <= 1'b1;
            ready_en_q    <= 1'b0;
        end else begin
            cmd_wr_ptr_q  <= cmd_wr_ptr_d;
            cmd_rd_ptr_q  <= cmd_rd_ptr_d;
            cmd_count_q   <= cmd_count_d;
            resp_wr_ptr_q <= resp_wr_ptr_d;
            resp_rd_ptr_q <= resp_rd_ptr_d;
            resp_count_q  <= resp_count_d;
            last_cs_n_q   <= spi_cs_n_i;
            ready_en_q    <= 1'b1;
        end
    end

    // Storage needs no reset: it is only observable through the counts.
    always_ff @(posedge clk_i) begin
        if (cmd_push) begin
            cmd_num_mem[cmd_wr_ptr_q]  <= cmd_num_data_i;
            cmd_data_mem[cmd_wr_ptr_q] <= cmd_data_i;
        end
        if (resp_push) begin
            resp_mem[resp_wr_ptr_q] <= spi_data_i;
        end
    end

endmodule

// File: tb/tb_spi_command_queue.sv
// tb_spi_command_queue
//   Bench for spi_command_queue.  A behavioural quick_spi stand-in answers
//   requests with a cs_n fall and a data_valid strobe; queues model the
//   accepted commands and the responses owed to the consumer.
module tb_spi_command_queue;
    localparam int NDW        = 4;
    localparam int W          = 16;
    localparam int RESP_DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [NDW-1:0] cmd_num_data = '0;
    logic [W-1:0]   cmd_data = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b0;
    logic [W-1:0]   resp_data;
    logic           spi_request;
    logic [NDW-1:0] spi_num_data;
    logic [W-1:0]   spi_data_out;
    logic [W-1:0]   spi_data_in = '0;
    logic           spi_dv = 1'b0;
    logic           spi_cs_n = 1'b1;
    logic           busy;

    spi_command_queue dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_num_data_i   (cmd_num_data),
        .cmd_data_i       (cmd_data),
        .resp_valid_o     (resp_valid),
        .resp_ready_i     (resp_ready),
        .resp_data_o      (resp_data),
        .spi_request_o    (spi_request),
        .spi_num_data_o   (spi_num_data),
        .spi_data_o       (spi_data_out),
        .spi_data_i       (spi_data_in),
        .spi_data_valid_i (spi_dv),
        .spi_cs_n_i       (spi_cs_n),
        .busy_o           (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;

    logic [NDW+W-1:0] cmd_model_q[$];   // {num_data, data} accepted, not yet launched
    logic [W-1:0]     exp_q[$];         // responses owed to the consumer, in order

    int launches  = 0;
    int chains    = 0;
    int resp_seen = 0;
    logic [W-1:0] last_resp = '0;

    // quick_spi stand-in controls
    bit em_enable = 1'b0;
    bit em_hold   = 1'b0;
    bit em_stray  = 1'b0;
    bit use_fixed = 1'b0;
    logic [W-1:0] rx_fixed = '0;
    int ack_delay = 1;
    int xfer_len  = 2;
    int em_phase  = 0;

    // consumer mode: 0 never ready, 1 always, 2 random, 3 one-cycle pulse
    int rr_mode = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- quick_spi stand-in ----------------
    initial begin : spi_model
        bit           req_s;
        bit           exp_req;
        int           em_cnt;
        logic [W-1:0] rx;
        em_cnt = 0;
        forever begin
            @(negedge clk);
            req_s = spi_request;
            @(posedge clk);
            #1;
            spi_dv = 1'b0;
            if (!em_enable) begin
                em_phase    = 0;
                spi_cs_n    = 1'b1;
                spi_dv      = em_stray;
                em_stray    = 1'b0;
                spi_data_in = W'($urandom);
            end else begin
                case (em_phase)
                    0: begin
                        spi_cs_n = 1'b1;
                        if (req_s) begin
                            em_phase = 1;
                            em_cnt   = ack_delay;
                        end
                    end
                    1: begin
                        if (!em_hold && em_cnt <= 1) begin
                            spi_cs_n = 1'b0;
                            em_phase = 2;
                            em_cnt   = xfer_len;
                            #1;
                            check("launch_req_at_fall", 32'(spi_request), 32'd1);
                            if (cmd_model_q.size() == 0) begin
                                check("launch_without_cmd", 32'(spi_request), 32'd0);
                            end else begin
                                check("launch_head", 32'({spi_num_data, spi_data_out}),
                                      32'(cmd_model_q[0]));
                                void'(cmd_model_q.pop_front());
                            end
                            check("launch_resp_space", 32'(exp_q.size() < RESP_DEPTH), 32'd1);
                            launches++;
                        end else begin
                            if (em_cnt > 1) em_cnt--;
                            #1;
                            check("launch_req_held", 32'(spi_request), 32'd1);
                            if (cmd_model_q.size() != 0)
                                check("launch_head_stable", 32'({spi_num_data, spi_data_out}),
                                      32'(cmd_model_q[0]));
                        end
                    end
                    2: begin
                        spi_cs_n = 1'b0;
                        if (em_cnt <= 1) begin
                            rx          = use_fixed ? rx_fixed : W'($urandom);
                            spi_dv      = 1'b1;
                            spi_data_in = rx;
                            exp_req = (cmd_model_q.size() > 0) && (exp_q.size() + 1 < RESP_DEPTH);
                            #1;
                            check("chain_req", 32'(spi_request), 32'(exp_req));
                            if (exp_req) begin
                                check("chain_head", 32'({spi_num_data, spi_data_out}),
                                      32'(cmd_model_q[0]));
                                chains++;
                            end
                            exp_q.push_back(rx);
                            em_phase = 3;
                        end else begin
                            em_cnt--;
                            #1;
                            check("active_req_low", 32'(spi_request), 32'd0);
                        end
                    end
                    3: begin
                        spi_cs_n = 1'b1;
                        #1;
                        // the word strobed last cycle must already be visible
                        check("resp_latency", 32'(resp_valid), 32'd1);
                        if (exp_q.size() == 1)
                            check("resp_latency_data", 32'(resp_data), 32'(exp_q[0]));
                        if (req_s) begin
                            em_phase = 1;
                            em_cnt   = ack_delay;
                        end else begin
                            em_phase = 0;
                        end
                    end
                    default: em_phase = 0;
                endcase
            end
        end
    end

    // ---------------- response consumer / scoreboard ----------------
    initial begin : resp_side
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       resp_ready = 1'b0;
                1:       resp_ready = 1'b1;
                2:       resp_ready = ($urandom_range(0, 3) != 0);
                3: begin resp_ready = 1'b1; rr_mode = 0; end
                default: resp_ready = 1'b0;
            endcase
            @(negedge clk);
            if (resp_valid && resp_ready) begin
                resp_seen++;
                last_resp = resp_data;
                if (exp_q.size() == 0)
                    check("resp_unexpected", 32'(resp_valid), 32'd0);
                else
                    check("resp_data", 32'(resp_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #400000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [NDW-1:0] num, input logic [W-1:0] data);
        int waited = 0;
        bit acc = 1'b0;
        cmd_valid    = 1'b1;
        cmd_num_data = num;
        cmd_data     = data;
        while (!acc && waited < 400) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            if (acc) cmd_model_q.push_back({num, data});
            #1;
            waited++;
        end
        cmd_valid = 1'b0;
        if (!acc) check("push_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            cycles(1);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        check({pfx, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({pfx, "_request"}, 32'(spi_request), 32'd0);
        check({pfx, "_busy"}, 32'(busy), 32'd0);
        check({pfx, "_resp_data"}, 32'(resp_data), 32'd0);
        check({pfx, "_num_data"}, 32'(spi_num_data), 32'd0);
        check({pfx, "_spi_data"}, 32'(spi_data_out), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int l0, r0, n, stall;

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        cycles(1);
        check("ready_after_rst", 32'(cmd_ready), 32'd1);
        em_enable = 1'b1;

        // single command
        rr_mode = 1; ack_delay = 2; xfer_len = 8;
        use_fixed = 1'b1; rx_fixed = 16'h3C5A;
        l0 = launches; r0 = resp_seen;
        push_cmd(4'd8, 16'hA5C3);
        @(negedge clk);
        check("lat_edge_n", 32'(spi_request), 32'd0);
        @(negedge clk);
        check("lat_edge_n1", 32'(spi_request), 32'd1);
        check("lat_head", 32'({spi_num_data, spi_data_out}), 32'({4'd8, 16'hA5C3}));
        cycles(1);
        wait_idle("single_idle");
        check("single_launches", 32'(launches - l0), 32'd1);
        check("single_resp_count", 32'(resp_seen - r0), 32'd1);
        check("single_resp_word", 32'(last_resp), 32'h3C5A);
        use_fixed = 1'b0;

        // back-to-back
        ack_delay = 1; xfer_len = 3;
        l0 = launches; r0 = chains;
        push_cmd(4'd15, 16'h1111);
        push_cmd(4'd0,  16'h2222);
        push_cmd(4'd7,  16'h3333);
        wait_idle("b2b_idle");
        check("b2b_launches", 32'(launches - l0), 32'd3);
        check("b2b_chains", 32'(chains - r0), 32'd2);

        // response backpressure
        rr_mode = 0; ack_delay = 1; xfer_len = 2;
        l0 = launches;
        for (int i = 0; i < 6; i++) push_cmd(NDW'($urandom), W'($urandom));
        cycles(40);
        check("bp_launches", 32'(launches - l0), 32'd4);
        check("bp_req_low", 32'(spi_request), 32'd0);
        check("bp_cmd_ready", 32'(cmd_ready), 32'd1);
        rr_mode = 3;
        cycles(40);
        check("bp_one_more", 32'(launches - l0), 32'd5);
        check("bp_req_low2", 32'(spi_request), 32'd0);
        rr_mode = 1;
        wait_idle("bp_idle");
        check("bp_total", 32'(launches - l0), 32'd6);

        // command FIFO full while cs_n never falls
        em_hold = 1'b1; ack_delay = 1; xfer_len = 2;
        l0 = launches;
        for (int i = 0; i < 4; i++) push_cmd(NDW'(i + 1), W'(16'hC000 + i));
        @(negedge clk);
        check("full_ready_low", 32'(cmd_ready), 32'd0);
        cycles(1);
        cmd_valid = 1'b1; cmd_num_data = 4'd5; cmd_data = 16'hC005;
        stall = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cmd_ready) stall++;
            cycles(1);
        end
        check("full_no_ready_while_held", 32'(stall), 32'd0);
        check("full_no_launch_while_held", 32'(launches - l0), 32'd0);
        em_hold = 1'b0;
        push_cmd(4'd5, 16'hC005);
        check("full_fifth_after_fall", 32'(launches - l0), 32'd1);
        wait_idle("full_idle");
        check("full_total", 32'(launches - l0), 32'd5);

        // delayed acknowledge
        ack_delay = 20; xfer_len = 2;
        l0 = launches; r0 = resp_seen;
        push_cmd(4'd9, 16'h0F0F);
        cycles(12);
        check("dack_no_pop_yet", 32'(launches - l0), 32'd0);
        check("dack_req_held", 32'(spi_request), 32'd1);
        wait_idle("dack_idle");
        check("dack_pops", 32'(launches - l0), 32'd1);
        check("dack_resp", 32'(resp_seen - r0), 32'd1);

        // randomized traffic
        l0 = launches; r0 = resp_seen;
        rr_mode = 2;
        for (int i = 0; i < 40; i++) begin
            ack_delay = $urandom_range(1, 4);
            xfer_len  = $urandom_range(1, 6);
            push_cmd((i == 0) ? 4'd0 : NDW'($urandom_range(0, 15)), W'($urandom));
            cycles($urandom_range(0, 3));
        end
        rr_mode = 1;
        wait_idle("rand_idle");
        check("rand_launches", 32'(launches - l0), 32'd40);
        check("rand_resps", 32'(resp_seen - r0), 32'd40);

        // reset in the middle of a transfer
        rr_mode = 0; ack_delay = 1; xfer_len = 12;
        l0 = launches;
        for (int i = 0; i < 4; i++) push_cmd(NDW'(i), W'(16'hD000 + i));
        n = 0;
        while (!(launches - l0 == 2 && em_phase == 2) && n < 300) begin
            cycles(1);
            n++;
        end
        check("mid_reached_active", 32'(launches - l0), 32'd2);
        @(negedge clk);
        #1;
        rst_n     = 1'b0;
        em_enable = 1'b0;
        #1;
        check_reset_outputs("midrst");
        cmd_model_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst_held");
        rst_n = 1'b1;
        cycles(1);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        em_stray = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stray_no_resp", 32'(resp_valid), 32'd0);
        end
        check("stray_idle", 32'(busy), 32'd0);
        cycles(1);
        em_enable = 1'b1;
        rr_mode = 1;
        cycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_command_queue.md
# spi_command_queue

Command/response sequencer that sits directly upstream of `quick_spi`. It buffers SPI transfer commands from the FPGA fabric and launches them on the master's `request_i`/`num_data_i`/`data_i` pins. It captures each `data_o` word on `data_valid_o` into a response FIFO with valid/ready backpressure. Response slots are reserved before launch, so the one-cycle `data_valid_o` strobe, which cannot be stalled, is never dropped.

## Interface
- `MAX_DATA_LENGTH`, 16: bits per device word; must match `quick_spi`.
- `NUM_DEVICES`, 1: parallel SPI devices; must match `quick_spi`.
- `CMD_DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `RESP_DEPTH`, 4: response FIFO entries; power of 2, ≥2.
- localparam `NUM_DATA_WIDTH` = `$clog2(MAX_DATA_LENGTH)`; `W` = `MAX_DATA_LENGTH*NUM_DEVICES`.

Ports:
- `clk_i`  in  1  system clock; one clock, shared with `quick_spi`.
- `rst_ni`  in  1  reset, asynchronous assert, active-low.
- `cmd_valid_i`  in  1  command offered.
- `cmd_ready_o`  out  1  command FIFO not full.
- `cmd_num_data_i`  in  `NUM_DATA_WIDTH`  bit count for the transfer.
- `cmd_data_i`  in  `W`  transmit word(s).
- `resp_valid_o`  out  1  response FIFO not empty.
- `resp_ready_i`  in  1  consumer accepts the head response.
- `resp_data_o`  out  `W`  received word(s), head of the response FIFO.
- `spi_request_o`  out  1  to `quick_spi.request_i`.
- `spi_num_data_o`  out  `NUM_DATA_WIDTH`  to `num_data_i`; head command.
- `spi_data_o`  out  `W`  to `data_i`; head command.
- `spi_data_i`  in  `W`  from `data_o`.
- `spi_data_valid_i`  in  1  from `data_valid_o`.
- `spi_cs_n_i`  in  1  from `cs_n_o`; used as the launch acknowledge.
- `busy_o`  out  1  high when the state is not IDLE or the command FIFO is non-empty.

## Operation
- **Command FIFO:**
  - Write when `cmd_valid_i && cmd_ready_o`.
  - Head drives `spi_num_data_o`/`spi_data_o` combinationally.
  - Head is popped on launch acknowledge.
- **Launch acknowledge:** `spi_cs_n_i` low while its registered copy `last_cs_n` is high, i.e. a `cs_n` falling edge. `last_cs_n` resets to 1.
- **Pending count `pend`:**
  - `pend = 1` when the state is not IDLE, else 0.
  - `can_launch` = command FIFO non-empty && `resp_count + pend < RESP_DEPTH`.
  - A same-cycle response pop is not credited.
- **State machine, states IDLE, LAUNCH, ACTIVE:**
  - IDLE: when `can_launch`, go to LAUNCH. `spi_request_o = 0`.
  - LAUNCH: `spi_request_o = 1`, with head data held stable. On a `cs_n` fall, pop the command and go to ACTIVE.
  - ACTIVE: `spi_request_o = spi_data_valid_i && can_launch`, with `pend` counted as 1.
    - On `spi_data_valid_i`: write `spi_data_i` to the response FIFO.
    - Then go to LAUNCH if `spi_request_o` was high, else IDLE.
    - This gives back-to-back chaining through `SAMPLE_STROBE`.
- **Requests during `quick_spi` RESET:** LAUNCH holds `spi_request_o` high until `cs_n` falls, so requests made while `quick_spi` is still in its RESET state are not lost.
- **`num_data` passthrough:** `cmd_num_data_i` is passed through unmodified, including 0.
- **Stray strobes:** `spi_data_valid_i` outside ACTIVE is ignored; no response is written.
- **Response FIFO:** read when `resp_valid_o && resp_ready_i`. Simultaneous read and write keeps the count unchanged.

## Timing
- **Reset values, while `rst_ni` is low:**
  - FIFOs empty; state IDLE.
  - `cmd_ready_o = 0`, `resp_valid_o = 0`, `spi_request_o = 0`, `busy_o = 0`.
  - `resp_data_o`, `spi_num_data_o`, `spi_data_o` = 0.
- **After reset release:** `cmd_ready_o = 1` from the first clock edge.
- **Reset mid-transfer:** both queues and the state are cleared immediately. A later `spi_data_valid_i` from the aborted transfer is ignored, since the state is IDLE.
- **Command to request latency:** command accepted at edge N into an empty, idle queue gives IDLE→LAUNCH at edge N+1 and `spi_request_o` high in cycle N+1.
- **`cmd_ready_o`, `resp_valid_o`:** from registered counts only. No same-cycle pop-to-push passthrough, so a full FIFO shows `ready = 0` even while being read.
- **Response latency:** `spi_data_valid_i` in cycle M gives `resp_valid_o` high in cycle M+1 with the captured word.
- **Chained launch:** during the `data_valid` cycle, `spi_data_o` already shows the next command, so `quick_spi` latches it in `SAMPLE_STROBE`.
- **Pointers:** wrap modulo depth. Counts are `$clog2(depth)+1` bits wide.

## Test plan
- **Single command:**
  - Stimulus: command `num_data = 8`, `data = 16'hA5C3`; model drives `cs_n` fall 2 cycles later and `data_valid` with `data_o = 16'h3C5A`.
  - Required: `spi_request_o` high exactly until the `cs_n` fall; one response `16'h3C5A`; `busy_o` low afterwards.
- **Back-to-back:**
  - Stimulus: 3 commands queued.
  - Required: `spi_request_o` high in the same cycle as each `spi_data_valid_i` with the next head on `spi_data_o`; responses in order; no IDLE between launches.
- **Response backpressure:**
  - Stimulus: `resp_ready_i = 0`, 6 commands, `RESP_DEPTH = 4`.
  - Required: exactly 4 launches, then `spi_request_o` stays low. Raising `resp_ready_i` for 1 cycle allows exactly one further launch.
- **Command full:**
  - Stimulus: 5 writes with `CMD_DEPTH = 4` while the model never lowers `cs_n`.
  - Required: `cmd_ready_o` low after 4 writes; the 5th is accepted only after the first `cs_n` fall.
- **Delayed acknowledge:**
  - Stimulus: model holds `cs_n` high 20 cycles, emulating `quick_spi` RESET.
  - Required: request and data stable for all 20 cycles; exactly one pop.
- **Reset mid-operation:**
  - Stimulus: assert `rst_ni` low in ACTIVE with 2 queued and 1 response pending; release; inject a stray `data_valid`.
  - Required: all outputs at reset values asynchronously; no response generated.
